// File: rtl/cmp_hazard_scoreboard.sv
// ID-stage comparator hazard scoreboard: per-GPR youngest writer tracking.
// Optional E-stage forwarding (code 11) enabled by `define CMP_FWD_EX_EN.
module cmp_hazard_scoreboard #(
   parameter int CNT_W    = 16,
   parameter int TNEW_MAX = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_wr_en,
   input  logic [4:0]       id_wr_addr,
   input  logic [1:0]       id_tnew,
   output logic             stall,
   output logic [1:0]       fwd_rs,
   output logic [1:0]       fwd_rt,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [1:0] ST_NONE = 2'd0;
   localparam logic [1:0] ST_E    = 2'd1;
   localparam logic [1:0] ST_M    = 2'd2;
   localparam logic [1:0] ST_W    = 2'd3;
   localparam logic [1:0] TMAX    = 2'(TNEW_MAX);

   logic [1:0]       stage_q [32];
   logic [1:0]       stage_d [32];
   logic [1:0]       rem_q   [32];
   logic [1:0]       rem_d   [32];
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic       en_rs, en_rt, haz_rs, haz_rt, issue;
   logic [1:0] tnew_c;
   logic [2:0] lk_rs, lk_rt;

   // Returns {hazard, fwd}; a stalled lookup reports fwd 00.
   function automatic logic [2:0] lookup(input logic [1:0] st,
                                         input logic [1:0] rm,
                                         input logic       en);
      logic [2:0] r;
      r = 3'b000;
      if (en) begin
         unique case (st)
            ST_NONE: r = 3'b000;
`ifdef CMP_FWD_EX_EN
            ST_E:    r = (rm == 2'd0) ? 3'b011 : 3'b100;
`else
            ST_E:    r = 3'b100;
`endif
            ST_M:    r = (rm == 2'd0) ? 3'b001 : 3'b100;
            ST_W:    r = 3'b010;
            default: r = 3'b000;
         endcase
      end
      return r;
   endfunction

   assign en_rs = reset & id_valid & id_use_rs & (id_rs != 5'd0);
   assign en_rt = reset & id_valid & id_use_rt & (id_rt != 5'd0);

   assign lk_rs = lookup(stage_q[id_rs], rem_q[id_rs], en_rs);
   assign lk_rt = lookup(stage_q[id_rt], rem_q[id_rt], en_rt);

   assign haz_rs    = lk_rs[2];
   assign haz_rt    = lk_rt[2];
   assign fwd_rs    = lk_rs[1:0];
   assign fwd_rt    = lk_rt[1:0];
   assign stall     = haz_rs | haz_rt;
   assign stall_cnt = reset ? cnt_q : '0;

   assign tnew_c = (id_tnew > TMAX) ? TMAX : id_tnew;
   assign issue  = id_valid & ~stall & id_wr_en & (id_wr_addr != 5'd0);

   always_comb begin
      for (int i = 0; i < 32; i++) begin
         stage_d[i] = ST_NONE;
         unique case (stage_q[i])
            ST_NONE: stage_d[i] = ST_NONE;
            ST_E:    stage_d[i] = ST_M;
            ST_M:    stage_d[i] = ST_W;
            ST_W:    stage_d[i] = ST_NONE;
            default: stage_d[i] = ST_NONE;
         endcase
         rem_d[i] = (rem_q[i] == 2'd0) ? 2'd0 : rem_q[i] - 2'd1;
      end
      // Issue wins over the advance of the same register.
      if (issue) begin
         stage_d[id_wr_addr] = ST_E;
         rem_d[id_wr_addr]   = tnew_c;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stall && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         stage_q <= '{default: ST_NONE};
         rem_q   <= '{default: 2'd0};
         cnt_q   <= '0;
      end else begin
         stage_q <= stage_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_cmp_hazard_scoreboard.sv
// Randomized + directed bench for cmp_hazard_scoreboard.
// Reference model: history of the last three issue slots (E, M, W).
module tb_cmp_hazard_scoreboard;

   localparam int CW  = 10;
   localparam int MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          id_valid;
   logic [4:0]    id_rs, id_rt, id_wr_addr;
   logic          id_use_rs, id_use_rt, id_wr_en;
   logic [1:0]    id_tnew;
   logic          stall;
   logic [1:0]    fwd_rs, fwd_rt;
   logic [CW-1:0] stall_cnt;

   int nvec = 0;
   int nerr = 0;
   bit run_cmp = 1'b0;

   // Model: h_*[k] is the instruction issued k cycles ago (k=1 sits in E).
   bit       h_v [1:3];
   bit [4:0] h_a [1:3];
   int       h_t [1:3];
   int       m_cnt;

   cmp_hazard_scoreboard #(.CNT_W(CW), .TNEW_MAX(2)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
      .id_tnew(id_tnew), .stall(stall),
      .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // {hazard, fwd} for one operand, from the youngest matching writer.
   function automatic bit [2:0] m_look(input bit [4:0] a, input bit use_i);
      if (!reset || !id_valid || !use_i || a == 5'd0) return 3'b000;
      for (int k = 1; k <= 3; k++) begin
         if (h_v[k] && h_a[k] == a) begin
            if (k == 1) begin
`ifdef CMP_FWD_EX_EN
               if (h_t[k] == 0) return 3'b011;
`endif
               return 3'b100;
            end
            if (k == 2) return (h_t[k] >= 2) ? 3'b100 : 3'b001;
            return 3'b010;
         end
      end
      return 3'b000;
   endfunction

   function automatic bit m_stall();
      bit [2:0] a, b;
      a = m_look(id_rs, id_use_rs);
      b = m_look(id_rt, id_use_rt);
      return a[2] | b[2];
   endfunction

   always @(posedge clk) begin
      if (!reset) begin
         for (int k = 1; k <= 3; k++) h_v[k] = 1'b0;
         m_cnt = 0;
      end else begin
         bit st;
         st = m_stall();
         for (int k = 3; k >= 2; k--) begin
            h_v[k] = h_v[k-1];
            h_a[k] = h_a[k-1];
            h_t[k] = h_t[k-1];
         end
         h_v[1] = id_valid && !st && id_wr_en && id_wr_addr != 5'd0;
         h_a[1] = id_wr_addr;
         h_t[1] = (int'(id_tnew) > 2) ? 2 : int'(id_tnew);
         if (st && m_cnt < MAX) m_cnt++;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (run_cmp) begin
         bit [2:0] a, b;
         a = m_look(id_rs, id_use_rs);
         b = m_look(id_rt, id_use_rt);
         chk("m_stall", int'(stall), int'(a[2] | b[2]));
         chk("m_fwd_rs", int'(fwd_rs), int'(a[1:0]));
         chk("m_fwd_rt", int'(fwd_rt), int'(b[1:0]));
         chk("m_cnt", int'(stall_cnt), reset ? m_cnt : 0);
      end
   end

   task automatic apply(input bit v, input bit [4:0] rs, input bit [4:0] rt,
                        input bit urs, input bit urt, input bit we,
                        input bit [4:0] wa, input bit [1:0] tn);
      @(posedge clk);
      #1;
      id_valid = v;  id_rs = rs;  id_rt = rt;
      id_use_rs = urs;  id_use_rt = urt;
      id_wr_en = we;  id_wr_addr = wa;  id_tnew = tn;
      @(negedge clk);
   endtask

   task automatic nop();
      apply(1, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic beq(input bit [4:0] rs, input bit [4:0] rt);
      apply(1, rs, rt, 1, 1, 0, 0, 0);
   endtask
   task automatic wr(input bit [4:0] a, input bit [1:0] t);
      apply(1, 0, 0, 0, 0, 1, a, t);
   endtask

   initial begin
      int it;
      reset = 1'b0;
      id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
      id_wr_en = 0; id_wr_addr = 0; id_tnew = 0;
      @(posedge clk);
      run_cmp = 1'b1;

      wr(3, 1);
      beq(3, 3);
      chk("rst_stall", int'(stall), 0);
      chk("rst_fwd_rs", int'(fwd_rs), 0);
      chk("rst_cnt", int'(stall_cnt), 0);
      reset = 1'b1;
      beq(1, 2);
      chk("beq12_stall", int'(stall), 0);
      chk("beq12_fwd", int'({fwd_rs, fwd_rt}), 0);

      wr(3, 1);
      beq(3, 0);
      chk("alu_stall1", int'(stall), 1);
      beq(3, 0);
      chk("alu_stall2", int'(stall), 0);
      chk("alu_fwd_rs", int'(fwd_rs), 1);
      chk("alu_cnt", int'(stall_cnt), 1);

      wr(4, 2);
      beq(0, 4);
      chk("ld_stall1", int'(stall), 1);
      beq(0, 4);
      chk("ld_stall2", int'(stall), 1);
      beq(0, 4);
      chk("ld_stall3", int'(stall), 0);
      chk("ld_fwd_rt", int'(fwd_rt), 2);
      chk("ld_cnt", int'(stall_cnt), 3);

      wr(5, 1); nop(); beq(5, 5);
      chk("gap1_stall", int'(stall), 0);
      chk("gap1_fwd", int'({fwd_rs, fwd_rt}), 4'b0101);
      wr(5, 1); nop(); nop(); beq(5, 5);
      chk("gap2_fwd", int'({fwd_rs, fwd_rt}), 4'b1010);
      wr(5, 1); nop(); nop(); nop(); beq(5, 5);
      chk("gap3_fwd", int'({fwd_rs, fwd_rt}), 0);

      wr(6, 2); wr(6, 1); nop(); beq(6, 0);
      chk("shadow_stall", int'(stall), 0);
      chk("shadow_fwd", int'(fwd_rs), 1);
      wr(0, 1); beq(0, 0);
      chk("r0_stall", int'(stall), 0);
      chk("r0_fwd", int'({fwd_rs, fwd_rt}), 0);

      wr(7, 3);
      beq(7, 0);
      chk("clamp_s1", int'(stall), 1);
      beq(7, 0);
      chk("clamp_s2", int'(stall), 1);
      beq(7, 0);
      chk("clamp_s3", int'(stall), 0);
      chk("clamp_fwd", int'(fwd_rs), 2);
      chk("clamp_cnt", int'(stall_cnt), 5);

      wr(8, 2);
      beq(8, 0);
      chk("mid_stall", int'(stall), 1);
      reset = 1'b0;
      beq(8, 0);
      chk("mid_rst_stall", int'(stall), 0);
      chk("mid_rst_cnt", int'(stall_cnt), 0);
      reset = 1'b1;
      beq(8, 0);
      chk("mid_post_stall", int'(stall), 0);
      chk("mid_post_fwd", int'(fwd_rs), 0);
      chk("mid_post_cnt", int'(stall_cnt), 0);

      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(99) != 0);
         apply($urandom_range(7) != 0,
               5'($urandom_range(7)), 5'($urandom_range(7)),
               1'($urandom), 1'($urandom), 1'($urandom),
               5'($urandom_range(7)), 2'($urandom));
      end

      reset = 1'b0;
      nop();
      reset = 1'b1;
      it = 0;
      while (m_cnt != MAX && it < 2000) begin
         wr(9, 2);
         beq(9, 0); beq(9, 0); beq(9, 0);
         it++;
      end
      if (m_cnt != MAX) begin
         nvec++;
         nerr++;
         $display("FAIL sat_budget: model count %0d expected %0d", m_cnt, MAX);
      end
      wr(9, 2);
      beq(9, 0);
      chk("sat_stall", int'(stall), 1);
      beq(9, 0);
      chk("sat_cnt", int'(stall_cnt), MAX);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/cmp_hazard_scoreboard.md
Name: cmp_hazard_scoreboard

Overview:
- Hazard controller for the ID-stage branch/movz comparator in the 5-stage MIPS pipeline.
- Tracks in-flight GPR writers across the E/M/W stages and selects forwarding sources for both comparator operands.
- Asserts stall when a needed operand is not yet forwardable, and keeps a stall-cycle counter for performance checks.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter
- TNEW_MAX, 2, largest legal id_tnew; larger inputs are clamped to this value

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- id_valid  in  1  ID holds a real instruction
- id_rs  in  5  comparator operand 1 register (RD1)
- id_rt  in  5  comparator operand 2 register (RD2)
- id_use_rs  in  1  comparator reads rs this cycle (beq, movz)
- id_use_rt  in  1  comparator reads rt this cycle
- id_wr_en  in  1  ID instruction writes a GPR (movz counts as a writer unconditionally)
- id_wr_addr  in  5  destination GPR
- id_tnew  in  2  cycles after entering E until the result sits in a forwardable register (ALU = 1, load = 2)
- stall  out  1  freeze PC/IF/ID and inject a bubble into E
- fwd_rs  out  2  rs source: 00 regfile, 01 M-stage result, 10 W-stage result
- fwd_rt  out  2  rt source, same encoding as fwd_rs
- stall_cnt  out  CNT_W  total stall cycles since reset, saturating

Behaviour:
- State: per GPR 1..31, stage[1:0] (0 none, 1 E, 2 M, 3 W) and rem[1:0]. $0 is never tracked; reads of $0 always give fwd 00 and no stall.
- Each GPR entry holds only its youngest in-flight writer. An older writer of the same register is shadowed, which is correct.
- Outputs are combinational from registered state plus the current ID inputs. While reset==0, stall=0, fwd_rs=fwd_rt=00, and stall_cnt reads 0.
- Per-operand hazard (op = rs or rt, only when id_valid and the matching id_use_* are set; otherwise no hazard and fwd 00):
  - stage==E -> stall
  - stage==M and rem>0 -> stall
  - stage==M and rem==0 -> fwd 01
  - stage==W -> fwd 10 (rem is always 0 in W)
  - stage==none -> fwd 00
- stall = OR of the rs and rt hazards. While stall is high, fwd outputs still reflect the current lookup.
- Clock edge with reset==0: all stage=0, all rem=0, stall_cnt=0. Reset mid-stall discards the stall.
- Clock edge otherwise, in this order:
  1. Advance every entry: E->M, M->W, W->none. rem decrements and saturates at 0.
  2. Issue: if id_valid & !stall & id_wr_en & id_wr_addr!=0, set entry[id_wr_addr] = {E, min(id_tnew, TNEW_MAX)}. Issue overrides the advance of the same entry.
  3. If stall, stall_cnt increments, holding at all-ones.
- A stalled instruction does not issue, so a bubble enters E and nothing is recorded. The entry it waits on still advances, so the stall always resolves within 2 cycles.
- An instruction that reads and writes the same register (e.g. movz rd=rs) uses the pre-issue entry for its lookup.
- id_tnew=0 at issue gives rem=0 in E. It still stalls unless the optional feature is enabled.

Optional Feature:
- Macro CMP_FWD_EX_EN.
- Defined: stage==E with rem==0 gives no stall and fwd code 11 (E-stage result, e.g. lui/jal link value). fwd outputs stay 2 bits wide.
- Undefined: code 11 is never produced, and stage==E always stalls.

Test Plan:
- Reset: hold reset=0 for 2 cycles with arbitrary inputs -> stall=0, fwd=00, stall_cnt=0. Release, then beq $1,$2 -> stall=0, fwd_rs=fwd_rt=00.
- ALU->beq back-to-back: addu $3 (tnew=1), then beq $3,$0 -> cycle 1 stall=1; cycle 2 stall=0, fwd_rs=01; stall_cnt=1.
- Load->beq: lw $4 (tnew=2), then beq $0,$4 -> stalls 2 cycles, then fwd_rt=01 is not allowed (rem=1 in M) ... sequence E: stall, M rem1: stall, W: fwd_rt=10, stall=0; stall_cnt=2.
- One-gap ALU: addu $5, nop, beq $5,$5 -> no stall, fwd_rs=fwd_rt=01. With two nops -> fwd=10. With three nops -> fwd=00.
- Shadowing: lw $6 (tnew=2), addu $6 (tnew=1), nop, beq $6,$0 -> fwd_rs=01 (addu in M) and no stall. Writes to $0 (addu $0) -> beq $0,$0 never stalls.
- Saturation and reset mid-op: force stall_cnt to 0xFFFF via a long hazard stream -> stays 0xFFFF. Assert reset during the stall -> next cycle all entries clear and stall=0.
